// File: rtl/aes_inverse_cipher_engine.sv
// Iterative AES inverse cipher: one inverse round per clock over a shared datapath,
// round keys fetched from an external store by key_index.
module aes_inverse_cipher_engine #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  output logic [3:0]   key_index,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] LAST_KEY    = 4'(NUM_ROUNDS);
  localparam logic [3:0] FIRST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t       state_reg;
  state_t       state_next;
  logic [3:0]   round_reg;
  logic [127:0] blk_reg;
  logic [127:0] plain_reg;
  logic         ready_reg;
  logic         accept;

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 through a short square-and-multiply chain.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // Byte gi sits at bits [127-8*gi -: 8]; row = gi%4, column = gi/4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    assign shifted[127-8*gi -: 8] = blk_reg[127-8*SRC -: 8];
    assign subbed[127-8*gi -: 8]  = inv_sbox(shifted[127-8*gi -: 8]);
  end

  assign keyed = subbed ^ round_key;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cols
    logic [7:0] a0, a1, a2, a3;
    assign a0 = keyed[127-32*gi -: 8];
    assign a1 = keyed[119-32*gi -: 8];
    assign a2 = keyed[111-32*gi -: 8];
    assign a3 = keyed[103-32*gi -: 8];
    assign mixed[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mixed[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mixed[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mixed[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  assign accept = in_valid & ready_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ROUND;
      ROUND:   if (round_reg == 4'd1) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    key_index = LAST_KEY;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      ROUND: begin
        key_index = round_reg;
        busy      = 1'b1;
      end
      FINAL: begin
        key_index = 4'd0;
        busy      = 1'b1;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ready is registered so it stays low throughout reset and never depends on inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_reg   <= '0;
      plain_reg <= '0;
      round_reg <= FIRST_ROUND;
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            blk_reg   <= cipher_in ^ round_key;
            round_reg <= FIRST_ROUND;
          end
        end
        ROUND: begin
          blk_reg <= mixed;
          if (round_reg != 4'd1) round_reg <= round_reg - 4'd1;
        end
        FINAL: begin
          blk_reg   <= keyed;
          plain_reg <= keyed;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = ready_reg;
  assign plain_out = plain_reg;

endmodule

// File: tb/tb_aes_inverse_cipher_engine.sv
// Bench for aes_inverse_cipher_engine: AES-128 and AES-256 instances, key store and
// forward-cipher reference model, scoreboard queue checked by per-instance monitors.
module tb_aes_inverse_cipher_engine;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] cipher_in [2];
  logic [3:0]   key_index [2];
  logic [127:0] round_key [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] plain_out [2];
  logic         busy      [2];

  logic [127:0] rk [2][16];
  logic [7:0]   sbox [256];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int           sel;
    logic [127:0] pt;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEYB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {127'd0, act}, {127'd0, exp});
  endtask

  task automatic chki(input string name, input int act, input int exp);
    chk(name, {96'd0, act}, {96'd0, exp});
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  function automatic int nr_of(input int sel);
    return (sel == 0) ? 10 : 14;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input int sel, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc  = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
        w[i] = w[i-nk] ^ tmp;
      end
    end
    for (int r = 0; r <= nr; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input int sel, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k;
    logic [127:0] res;
    int           nr;
    nr = nr_of(sel);
    k  = rk[sel][0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
          s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      k = rk[sel][r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input int sel, input logic [127:0] ct, input logic [127:0] pt,
                      input bit hold, output int acc);
    exp_t e;
    cipher_in[sel] = ct;
    in_valid[sel]  = 1'b1;
    acc = -1;
    for (int t = 0; t < 60; t++) begin
      if (in_ready[sel]) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clock);
    end
    if (acc < 0) begin
      fail_now("accept_timeout");
      in_valid[sel] = 1'b0;
    end else begin
      chki("idle_key_index", int'(key_index[sel]), nr_of(sel));
      e.sel = sel;
      e.pt  = pt;
      e.acc = acc;
      exp_q.push_back(e);
      @(negedge clock);
      if (!hold) in_valid[sel] = 1'b0;
    end
  endtask

  task automatic wait_valid(input int sel);
    for (int t = 0; t < 40; t++) begin
      if (out_valid[sel]) break;
      @(negedge clock);
    end
    if (!out_valid[sel]) fail_now("out_valid_timeout");
  endtask

  task automatic drain(input int sel, input int stall);
    wait_valid(sel);
    repeat (stall) @(negedge clock);
    out_ready[sel] = 1'b1;
    @(negedge clock);
    chk1("release_valid", out_valid[sel], 1'b0);
    chk1("release_ready", in_ready[sel], 1'b1);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int NR = (gi == 0) ? 10 : 14;

    assign round_key[gi] = rk[gi][key_index[gi]];

    aes_inverse_cipher_engine #(.NUM_ROUNDS(NR)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .cipher_in (cipher_in[gi]),
      .key_index (key_index[gi]),
      .round_key (round_key[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .plain_out (plain_out[gi]),
      .busy      (busy[gi])
    );

    initial begin : monitor
      logic         pv;
      logic [127:0] held;
      logic [3:0]   kseq[$];
      int           idx;
      bit           ok;
      pv   = 1'b0;
      held = '0;
      forever begin
        @(posedge clock);
        #1;
        if (reset) begin
          kseq.delete();
          pv = 1'b0;
        end else begin
          if (busy[gi]) kseq.push_back(key_index[gi]);
          if (out_valid[gi] && !pv) begin
            idx = -1;
            foreach (exp_q[k]) if (idx < 0 && exp_q[k].sel == gi) idx = k;
            if (idx < 0) fail_now("spurious_out_valid");
            else begin
              chk("plain_out", plain_out[gi], exp_q[idx].pt);
              chki("latency", cyc - exp_q[idx].acc, NR);
              ok = (kseq.size() == NR);
              for (int i = 0; i < kseq.size() && i < NR; i++)
                if (int'(kseq[i]) != NR - 1 - i) ok = 1'b0;
              chk1("key_sequence", ok, 1'b1);
              $display("dut%0d block pt=%h latency=%0d", gi, plain_out[gi], cyc - exp_q[idx].acc);
              exp_q.delete(idx);
            end
            kseq.delete();
            held = plain_out[gi];
          end else if (out_valid[gi] && pv) begin
            chk("hold_plain_out", plain_out[gi], held);
          end
          pv = out_valid[gi];
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int           acc;
    int           acc2;
    logic [7:0]   inv;
    logic [255:0] key;
    logic [127:0] pt;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      cipher_in[s] = '0;
      out_ready[s] = 1'b1;
      for (int r = 0; r < 16; r++) rk[s][r] = '0;
    end
    expand(0, KEY1, 4);
    expand(1, KEY3, 8);

    reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      chk1("rst_in_ready", in_ready[s], 1'b0);
      chk1("rst_out_valid", out_valid[s], 1'b0);
      chk1("rst_busy", busy[s], 1'b0);
      chki("rst_key_index", int'(key_index[s]), nr_of(s));
      chk("rst_plain_out", plain_out[s], 128'h0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk1("post_rst_ready0", in_ready[0], 1'b1);
    chk1("post_rst_ready1", in_ready[1], 1'b1);

    chk("model_c1", encrypt(0, PT1), CT1);
    chk("model_c3", encrypt(1, PT1), CT3);
    chk("round_key_10", round_key[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    send(0, CT1, PT1, 1'b0, acc);
    drain(0, 0);

    out_ready[0] = 1'b0;
    send(0, CT1, PT1, 1'b0, acc);
    wait_valid(0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        cipher_in[0] = {$urandom, $urandom, $urandom, $urandom};
        in_valid[0]  = 1'b1;
      end
      if (k == 3) in_valid[0] = 1'b0;
      @(negedge clock);
      chk1("bp_out_valid", out_valid[0], 1'b1);
      chk1("bp_in_ready", in_ready[0], 1'b0);
    end
    out_ready[0] = 1'b1;
    @(negedge clock);
    chk1("bp_release_valid", out_valid[0], 1'b0);
    chk1("bp_release_ready", in_ready[0], 1'b1);

    expand(0, KEYB, 4);
    chk("model_appb", encrypt(0, PTB), CTB);
    send(0, CTB, PTB, 1'b1, acc);
    send(0, CTB, PTB, 1'b0, acc2);
    chki("b2b_gap", acc2 - acc, 12);
    drain(0, 0);

    expand(0, KEY1, 4);
    send(0, CT1, PT1, 1'b0, acc);
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk1("mid_rst_out_valid", out_valid[0], 1'b0);
    chk1("mid_rst_busy", busy[0], 1'b0);
    chk1("mid_rst_in_ready", in_ready[0], 1'b0);
    chki("mid_rst_key_index", int'(key_index[0]), 10);
    chk("mid_rst_plain_out", plain_out[0], 128'h0);
    for (int k = exp_q.size() - 1; k >= 0; k--) if (exp_q[k].sel == 0) exp_q.delete(k);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk1("aborted_no_valid", out_valid[0], 1'b0);
    send(0, CT1, PT1, 1'b0, acc);
    drain(0, 0);

    send(1, CT3, PT1, 1'b0, acc);
    drain(1, 0);

    for (int it = 0; it < 6; it++) begin
      automatic int sel = it % 2;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (sel == 0) key[127:0] = '0;
      expand(sel, key, (sel == 0) ? 4 : 8);
      pt = {$urandom, $urandom, $urandom, $urandom};
      out_ready[sel] = 1'b0;
      send(sel, encrypt(sel, pt), pt, 1'b0, acc);
      drain(sel, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clock);
    foreach (exp_q[k]) fail_now("block_never_completed");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
